// File: rtl/reg_slice_pkg.sv
// Shared types for the two-entry valid/ready register slice.
package reg_slice_pkg;

  // Slice fill state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

endpackage

// File: rtl/reg_slice_entry.sv
// Single data register of the slice: load enable, synchronous clear and
// asynchronous reset, both returning the register to RESET_VALUE.
module reg_slice_entry #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: clear wins over load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = RESET_VALUE;
    end else if (load) begin
      data_d = d;
    end
  end

  // Data register with async reset to the same value clear produces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_slice.sv
// Two-entry valid/ready skid buffer. The primary entry always drives
// out_data; the skid entry catches the one word that arrives while the
// consumer stalls, so in_ready depends only on registered state and clear.
module reg_slice
  import reg_slice_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  slice_state_t     state_q;
  slice_state_t     state_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             prim_load;
  logic             prim_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] prim_d;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs come straight from the state register; clear is the
  // only combinational term and it blocks acceptance during a flush.
  assign in_ready  = (state_q != FULL) && !clear;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign prim_d    = prim_from_skid ? skid_q : in_data;

  // Next-state and entry load decode; clear forces EMPTY and the entries
  // apply their own clear, so nothing else is loaded that cycle.
  always_comb begin
    state_d        = state_q;
    prim_load      = 1'b0;
    prim_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            prim_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            prim_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            prim_load      = 1'b1;
            prim_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Fill-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  reg_slice_entry #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_primary (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (prim_load),
    .d     (prim_d),
    .q     (out_data)
  );

  reg_slice_entry #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_reg_slice.sv
// Directed bench for reg_slice with RESET_VALUE = 4'hA.
module tb_reg_slice;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_err    = 0;

  reg_slice #(
    .WIDTH       (4),
    .RESET_VALUE (4'hA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] d, input logic v,
                           input logic rdy, input logic [1:0] occ);
    check({tag, ".out_data"},  32'(out_data),  32'(d));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    rst_n     = 1'b1;
    clear     = 1'b0;
    in_data   = 4'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset asserted before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_out("reset_pre_edge", 4'hA, 1'b0, 1'b1, 2'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_out("reset_release", 4'hA, 1'b0, 1'b1, 2'd0);

    // Streaming 1..4 with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 4'(i);
      tick();
      check_out($sformatf("stream%0d", i), 4'(i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    check_out("drain_keeps_last", 4'h4, 1'b0, 1'b1, 2'd0);

    // Backpressure: 5 and 6 fill the slice, 7 is held upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    tick();
    check_out("bp_first", 4'h5, 1'b1, 1'b1, 2'd1);
    in_data = 4'h6;
    tick();
    check_out("bp_full", 4'h5, 1'b1, 1'b0, 2'd2);
    in_data = 4'h7;
    tick();
    check_out("bp_stall_stable", 4'h5, 1'b1, 1'b0, 2'd2);
    out_ready = 1'b1;
    tick();
    check_out("bp_release6", 4'h6, 1'b1, 1'b1, 2'd1);
    tick();
    check_out("bp_release7", 4'h7, 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("bp_drained", 4'h7, 1'b0, 1'b1, 2'd0);

    // Clear while FULL holding 5,6.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    check_out("clr_prefill", 4'h5, 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    check("clr_in_ready_low", 32'(in_ready), 32'd0);
    check("clr_same_cycle_valid", 32'(out_valid), 32'd1);
    tick();
    clear = 1'b0;
    #1;
    check_out("clr_after", 4'hA, 1'b0, 1'b1, 2'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h8;
    tick();
    check_out("clr_no_stale6", 4'h8, 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("clr_drain", 4'h8, 1'b0, 1'b1, 2'd0);

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h9;
    tick();
    in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    check_out("arst_prefill", 4'h9, 1'b1, 1'b0, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    check_out("arst_immediate", 4'hA, 1'b0, 1'b1, 2'd0);
    tick();
    check_out("arst_held", 4'hA, 1'b0, 1'b1, 2'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'hC;
    tick();
    check_out("arst_first_word", 4'hC, 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_out("arst_drain", 4'hC, 1'b0, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
